// File: rtl/add_issue.sv
// Stream initiator for the 64-bit add wrapper: issues N operand pairs from two
// arithmetic sequences under rdy/vld flow control and sums the returned results.
module add_issue #(
    parameter int CNT_W   = 16,
    parameter int MAX_OUT = 32
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [63:0]      i_a0,
    input  logic [63:0]      i_b0,
    input  logic [63:0]      i_ainc,
    input  logic [63:0]      i_binc,
    output logic             o_busy,
    output logic             o_done,
    output logic [63:0]      o_sum,
    output logic             o_err,
    output logic [63:0]      o_a,
    output logic [63:0]      o_b,
    output logic             o_vld,
    input  logic             i_rdy,
    input  logic [63:0]      i_res,
    input  logic             i_res_vld
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   returned_q, returned_d;
    logic [OUT_W-1:0]   outst_q, outst_d;
    logic [63:0]        ainc_q, ainc_d;
    logic [63:0]        binc_q, binc_d;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic [63:0]        sum_q, sum_d;
    logic               err_q, err_d;
    logic               push;
    logic               res_ok;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        outst_d    = outst_q;
        ainc_d     = ainc_q;
        binc_d     = binc_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        err_d      = err_q;

        // Gate on the registered in-flight count: a same-cycle return never unlocks a push.
        push   = (state_q == S_ISSUE) && (issued_q != cnt_q) && i_rdy
                 && (outst_q < OUT_W'(MAX_OUT));
        res_ok = i_res_vld && (outst_q != '0);

        if (push) begin
            a_d      = a_q + ainc_q;
            b_d      = b_q + binc_q;
            issued_d = issued_q + CNT_W'(1);
        end
        if (res_ok) begin
            sum_d      = sum_q + i_res;
            returned_d = returned_q + CNT_W'(1);
        end
        if (i_res_vld && (outst_q == '0)) begin
            err_d = 1'b1;
        end
        if (push && !res_ok) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!push && res_ok) begin
            outst_d = outst_q - OUT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_ISSUE;
                    cnt_d      = i_cnt;
                    ainc_d     = i_ainc;
                    binc_d     = i_binc;
                    a_d        = i_a0;
                    b_d        = i_b0;
                    issued_d   = '0;
                    returned_d = '0;
                    sum_d      = '0;
                    err_d      = 1'b0;
                end
            end
            S_ISSUE: if (issued_q == cnt_q) state_d = S_DRAIN;
            S_DRAIN: if (returned_q == cnt_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            outst_q    <= '0;
            ainc_q     <= '0;
            binc_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            outst_q    <= outst_d;
            ainc_q     <= ainc_d;
            binc_q     <= binc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
        end
    end

    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_DONE);
    assign o_sum  = sum_q;
    assign o_err  = err_q;
    assign o_a    = a_q;
    assign o_b    = b_q;
    assign o_vld  = push;

endmodule

// File: tb/tb_add_issue.sv
// Randomized bench for add_issue: a latency-configurable adder model feeds results back,
// and a sequence/flow-control reference predicts pushes, operands, sum and done timing.
module tb_add_issue;

    localparam int CNT_W   = 16;
    localparam int MAX_OUT = 2;

    logic             ck = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_cnt;
    logic [63:0]      i_a0, i_b0, i_ainc, i_binc;
    logic             o_busy, o_done, o_err, o_vld;
    logic [63:0]      o_sum, o_a, o_b;
    logic             i_rdy;
    logic [63:0]      i_res;
    logic             i_res_vld;

    int n_tests = 0;
    int n_fail  = 0;

    // Results in flight inside the adder model, with the cycle each one returns.
    logic [63:0] exp_q[$];
    int          due_q[$];

    add_issue #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
        .ck(ck), .rst(rst),
        .i_start(i_start), .i_cnt(i_cnt),
        .i_a0(i_a0), .i_b0(i_b0), .i_ainc(i_ainc), .i_binc(i_binc),
        .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum), .o_err(o_err),
        .o_a(o_a), .o_b(o_b), .o_vld(o_vld), .i_rdy(i_rdy),
        .i_res(i_res), .i_res_vld(i_res_vld)
    );

    always #5 ck = ~ck;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check64({tag, "_busy"}, o_busy, 0);
        check64({tag, "_done"}, o_done, 0);
        check64({tag, "_sum"},  o_sum,  0);
        check64({tag, "_err"},  o_err,  0);
        check64({tag, "_a"},    o_a,    0);
        check64({tag, "_b"},    o_b,    0);
        check64({tag, "_vld"},  o_vld,  0);
    endtask

    // rdy_mode: 0 always high, 1 pattern 1,0,0 repeating, 2 random.
    // stray_c: cycle at which a junk start is pulsed while busy (0 = none).
    // abort_c: cycle after which rst is pulsed mid-command (0 = none).
    task automatic run_cmd(input int cnt, input logic [63:0] a0, input logic [63:0] b0,
                           input logic [63:0] ainc, input logic [63:0] binc,
                           input int lat, input int rdy_mode, input int stray_c,
                           input int abort_c);
        int          pushed, returned, last_push, last_ret, done_c, c;
        logic [63:0] exp_sum, exp_a, exp_b;
        logic        exp_vld, done_seen, aborted;

        exp_q.delete();
        due_q.delete();
        @(negedge ck);
        i_start   = 1'b1;
        i_cnt     = CNT_W'(cnt);
        i_a0      = a0;
        i_b0      = b0;
        i_ainc    = ainc;
        i_binc    = binc;
        i_rdy     = 1'b0;
        i_res_vld = 1'b0;
        @(posedge ck);

        pushed    = 0;
        returned  = 0;
        last_push = 0;
        last_ret  = 0;
        exp_sum   = '0;
        done_seen = 1'b0;
        aborted   = 1'b0;
        done_c    = (cnt == 0) ? 3 : 1000000;

        for (c = 1; c <= 3000 && !done_seen; c++) begin
            @(negedge ck);
            i_start = (c == stray_c);
            if (c == stray_c) begin
                i_cnt  = CNT_W'($urandom_range(1, 50));
                i_a0   = rand64();
                i_b0   = rand64();
                i_ainc = rand64();
                i_binc = rand64();
            end
            case (rdy_mode)
                0:       i_rdy = 1'b1;
                1:       i_rdy = ((c - 1) % 3 == 0);
                default: i_rdy = 1'($urandom_range(0, 1));
            endcase
            if (due_q.size() > 0 && due_q[0] == c) begin
                i_res_vld = 1'b1;
                i_res     = exp_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                i_res_vld = 1'b0;
                i_res     = rand64();
            end
            #1;
            exp_vld = (pushed < cnt) && i_rdy && ((pushed - returned) < MAX_OUT);
            check64("vld", o_vld, exp_vld);
            check64("busy", o_busy, 1);
            check64("done", o_done, (c == done_c));
            if (o_done) done_seen = 1'b1;
            if (o_vld && pushed < cnt) begin
                exp_a = a0 + ainc * 64'(pushed);
                exp_b = b0 + binc * 64'(pushed);
                check64("op_a", o_a, exp_a);
                check64("op_b", o_b, exp_b);
                exp_sum = exp_sum + exp_a + exp_b;
                exp_q.push_back(o_a + o_b);
                due_q.push_back(c + lat);
                pushed++;
                last_push = c;
            end
            if (i_res_vld) begin
                returned++;
                last_ret = c;
                if (returned == cnt) begin
                    done_c = ((last_push + 2 > last_ret + 1) ? last_push + 2 : last_ret + 1) + 1;
                end
            end
            if (c == abort_c) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("abort");
            @(negedge ck);
            rst       = 1'b0;
            i_res_vld = 1'b0;
            i_start   = 1'b0;
            for (int k = c + 1; k <= c + 50 && due_q.size() > 0; k++) begin
                if (k > c + 1) @(negedge ck);
                if (due_q[0] == k) begin
                    i_res_vld = 1'b1;
                    i_res     = exp_q.pop_front();
                    void'(due_q.pop_front());
                end else begin
                    i_res_vld = 1'b0;
                end
                #1;
                check64("abort_vld", o_vld, 0);
                check64("abort_busy", o_busy, 0);
            end
            @(negedge ck);
            i_res_vld = 1'b0;
            #1;
            check64("abort_err", o_err, 1);
            check64("abort_sum", o_sum, 0);
            return;
        end

        check64("done_seen", done_seen, 1);
        check64("pushes", pushed, cnt);
        check64("sum", o_sum, exp_sum);
        check64("err", o_err, 0);
        @(negedge ck);
        i_start   = 1'b0;
        i_res_vld = 1'b0;
        #1;
        check64("idle_busy", o_busy, 0);
        check64("idle_done", o_done, 0);
        check64("idle_sum", o_sum, exp_sum);
    endtask

    initial begin
        rst       = 1'b1;
        i_start   = 1'b0;
        i_cnt     = '0;
        i_a0      = '0;
        i_b0      = '0;
        i_ainc    = '0;
        i_binc    = '0;
        i_rdy     = 1'b0;
        i_res     = '0;
        i_res_vld = 1'b0;
        @(negedge ck);
        #1;
        check_reset_outputs("reset");
        @(negedge ck);
        rst = 1'b0;

        // Directed cases.
        run_cmd(4, 64'd1, 64'd10, 64'd1, 64'd2, 5, 0, 0, 0);
        check64("t1_sum", o_sum, 64'd62);
        run_cmd(0, rand64(), rand64(), rand64(), rand64(), 3, 0, 0, 0);
        check64("t2_sum", o_sum, 64'd0);
        run_cmd(6, 64'd100, 64'd7, 64'd3, 64'd5, 10, 0, 0, 0);
        run_cmd(8, 64'd5, 64'd9, 64'd11, 64'd13, 1, 1, 0, 0);
        run_cmd(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64'd0, 2, 0, 0, 0);
        check64("t5_sum", o_sum, 64'd3);

        // Stray result in IDLE sets a sticky error; sum untouched.
        @(negedge ck);
        i_res_vld = 1'b1;
        i_res     = rand64();
        @(negedge ck);
        i_res_vld = 1'b0;
        #1;
        check64("stray_err", o_err, 1);
        check64("stray_sum", o_sum, 64'd3);
        repeat (3) @(negedge ck);
        #1;
        check64("stray_err_hold", o_err, 1);

        // Start while busy is ignored; also clears the sticky error.
        run_cmd(5, 64'd20, 64'd30, 64'd2, 64'd4, 2, 0, 2, 0);
        run_cmd(6, rand64(), rand64(), rand64(), rand64(), 4, 2, 7, 0);

        // Reset mid-ISSUE; later in-flight results flag an error.
        run_cmd(8, 64'd1, 64'd1, 64'd1, 64'd1, 5, 0, 0, 3);

        // Random commands.
        for (int i = 0; i < 12; i++) begin
            run_cmd($urandom_range(0, 12), rand64(), rand64(), rand64(), rand64(),
                    $urandom_range(1, 6), $urandom_range(0, 2), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
